// File: rtl/alu_op_sequencer_if.sv
// Bundle of the instruction handshake, ALU control, memory strobes and status signals
// between alu_op_sequencer and its environment.
//   slave  : the sequencer side (takes the instruction, zero and mem_ack; drives everything else)
//   master : the environment side (drives the instruction, zero and mem_ack)
// Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready.
//   instr_ready is high only in IDLE. instr_valid may be held or dropped at any time.
//   While instr_ready is low, instr_valid and instr are ignored.
// state_dbg exposes the sequencer FSM state: 0 IDLE, 1 DECODE, 2 EXEC, 3 MEM, 4 WB.
interface alu_op_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ack;
  logic [3:0]       ALUoperation;
  logic             op2_sel;
  logic [31:0]      imm;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             branch_taken;
  logic             done;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state_dbg;

  modport slave (
    input  instr_valid, instr, zero, mem_ack,
    output instr_ready, ALUoperation, op2_sel, imm, rs1, rs2, rd,
           reg_write, mem_read, mem_write, branch_taken, done, illegal,
           bus_err, retired, state_dbg
  );

  modport master (
    output instr_valid, instr, zero, mem_ack,
    input  instr_ready, ALUoperation, op2_sel, imm, rs1, rs2, rd,
           reg_write, mem_read, mem_write, branch_taken, done, illegal,
           bus_err, retired, state_dbg
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control FSM for a small RV32I datapath. Accepts one instruction per
// handshake, decodes it into an ALU operation code and operand-2 select, then steps
// through EXEC, an optional MEM phase (lw/sw, with a timeout) and WB.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any instruction in flight)
//   bus   : alu_op_sequencer_if.slave (handshake, ALU control, strobes, status, counter)
module alu_op_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_op_sequencer_if.slave    bus
);

  localparam int CW = $clog2(MEM_TIMEOUT);

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Instruction class, decides the path after EXEC and which WB strobes fire.
  typedef enum logic [1:0] {
    K_ALU = 2'd0,
    K_LW  = 2'd1,
    K_SW  = 2'd2,
    K_BEQ = 2'd3
  } kind_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_instr;
  logic [31:0]      r_imm;
  logic [3:0]       r_aluop;
  logic             r_op2_sel;
  kind_t            r_kind;
  logic             r_br_flag;
  logic [CW-1:0]    r_mem_cnt;
  logic [CNT_W-1:0] r_retired;

  logic [31:0]      w_imm_in;
  logic             w_dec_legal;
  logic [3:0]       w_dec_aluop;
  logic             w_dec_op2_sel;
  kind_t            w_dec_kind;
  logic             w_handshake;
  logic             w_mem_timeout;

  logic             w_ready, w_illegal, w_bus_err, w_done;
  logic             w_reg_write, w_mem_read, w_mem_write, w_branch;

  logic [6:0]       w_opc;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;

  assign w_opc = r_instr[6:0];
  assign w_f3  = r_instr[14:12];
  assign w_f7  = r_instr[31:25];

  assign w_handshake   = (r_state == S_IDLE) && bus.instr_valid;
  assign w_mem_timeout = (r_mem_cnt == CW'(MEM_TIMEOUT - 1));

  // Immediate format is chosen from the incoming opcode so it is ready at DECODE.
  always_comb begin
    w_imm_in = {{20{bus.instr[31]}}, bus.instr[31:20]};
    case (bus.instr[6:0])
      OPC_SW:  w_imm_in = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      OPC_BEQ: w_imm_in = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                           bus.instr[30:25], bus.instr[11:8], 1'b0};
      default: ;
    endcase
  end

  // Decoder over the captured instruction.
  always_comb begin
    w_dec_legal   = 1'b0;
    w_dec_aluop   = ALU_ADD;
    w_dec_op2_sel = 1'b0;
    w_dec_kind    = K_ALU;
    case (w_opc)
      OPC_R: begin
        if (w_f3 == 3'b000 && w_f7 == 7'b0000000) begin
          w_dec_legal = 1'b1; w_dec_aluop = ALU_ADD;
        end else if (w_f3 == 3'b000 && w_f7 == 7'b0100000) begin
          w_dec_legal = 1'b1; w_dec_aluop = ALU_SUB;
        end else if (w_f3 == 3'b111 && w_f7 == 7'b0000000) begin
          w_dec_legal = 1'b1; w_dec_aluop = ALU_AND;
        end else if (w_f3 == 3'b110 && w_f7 == 7'b0000000) begin
          w_dec_legal = 1'b1; w_dec_aluop = ALU_OR;
        end
      end
      OPC_I: begin
        w_dec_op2_sel = 1'b1;
        if (w_f3 == 3'b000) begin
          w_dec_legal = 1'b1; w_dec_aluop = ALU_ADD;
        end else if (w_f3 == 3'b111) begin
          w_dec_legal = 1'b1; w_dec_aluop = ALU_AND;
        end else if (w_f3 == 3'b110) begin
          w_dec_legal = 1'b1; w_dec_aluop = ALU_OR;
        end
      end
      OPC_LW: begin
        w_dec_legal   = (w_f3 == 3'b010);
        w_dec_op2_sel = 1'b1;
        w_dec_kind    = K_LW;
      end
      OPC_SW: begin
        w_dec_legal   = (w_f3 == 3'b010);
        w_dec_op2_sel = 1'b1;
        w_dec_kind    = K_SW;
      end
      OPC_BEQ: begin
        w_dec_legal   = (w_f3 == 3'b000);
        w_dec_aluop   = ALU_SUB;
        w_dec_kind    = K_BEQ;
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_illegal   = 1'b0;
    w_bus_err   = 1'b0;
    w_done      = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.instr_valid) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_dec_legal) w_state_nxt = S_EXEC;
        else begin
          w_illegal   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        if (r_kind == K_LW || r_kind == K_SW) w_state_nxt = S_MEM;
        else                                  w_state_nxt = S_WB;
      end
      S_MEM: begin
        w_mem_read  = (r_kind == K_LW);
        w_mem_write = (r_kind == K_SW);
        // An ack in the final allowed cycle still completes the access.
        if (bus.mem_ack) w_state_nxt = S_WB;
        else if (w_mem_timeout) begin
          w_bus_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WB: begin
        w_done      = 1'b1;
        w_reg_write = (r_kind == K_ALU) || (r_kind == K_LW);
        w_branch    = (r_kind == K_BEQ) && r_br_flag;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr   <= '0;
      r_imm     <= '0;
      r_aluop   <= ALU_AND;
      r_op2_sel <= 1'b0;
      r_kind    <= K_ALU;
      r_br_flag <= 1'b0;
      r_mem_cnt <= '0;
      r_retired <= '0;
    end else begin
      if (w_handshake) begin
        r_instr <= bus.instr;
        r_imm   <= w_imm_in;
      end
      // ALU controls only change on a legal decode and hold until the next one.
      if (r_state == S_DECODE && w_dec_legal) begin
        r_aluop   <= w_dec_aluop;
        r_op2_sel <= w_dec_op2_sel;
        r_kind    <= w_dec_kind;
        r_br_flag <= 1'b0;
      end
      if (r_state == S_EXEC) begin
        r_mem_cnt <= '0;
        if (r_kind == K_BEQ) r_br_flag <= bus.zero;
      end
      if (r_state == S_MEM) r_mem_cnt <= r_mem_cnt + CW'(1);
      if (r_state == S_WB)  r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign bus.instr_ready  = w_ready;
  assign bus.ALUoperation = r_aluop;
  assign bus.op2_sel      = r_op2_sel;
  assign bus.imm          = r_imm;
  assign bus.rs1          = r_instr[19:15];
  assign bus.rs2          = r_instr[24:20];
  assign bus.rd           = r_instr[11:7];
  assign bus.reg_write    = w_reg_write;
  assign bus.mem_read     = w_mem_read;
  assign bus.mem_write    = w_mem_write;
  assign bus.branch_taken = w_branch;
  assign bus.done         = w_done;
  assign bus.illegal      = w_illegal;
  assign bus.bus_err      = w_bus_err;
  assign bus.retired      = r_retired;
  assign bus.state_dbg    = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: reset, add, beq taken/not taken, lw with a late
// ack, sw timeout, illegal encoding, reset during MEM, counter wrap and instr_valid
// held outside IDLE. Inputs change 1 time unit after posedge or at negedge; outputs
// are sampled at negedge.
module tb_alu_op_sequencer;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 16;

  localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_ADD4 = 32'h00208233; // add x4,x1,x2
  localparam logic [31:0] I_BEQ  = 32'h00208463; // beq x1,x2,+8
  localparam logic [31:0] I_LW   = 32'h0040A183; // lw x3,4(x1)
  localparam logic [31:0] I_SW   = 32'h0020A423; // sw x2,8(x1)

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_op_sequencer_if #(.CNT_W(CNT_W)) bus ();

  alu_op_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: wait (bounded) for instr_ready, then hand over one instruction.
  // Returns 1 unit after the handshake edge; the next negedge is in DECODE.
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: instr_ready=%b required 1 within 50 cycles", bus.instr_ready);
    end
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
  endtask

  // Driver: complete one add (DECODE, EXEC, WB) and return in the following IDLE cycle.
  task automatic run_add();
    send(I_ADD);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.zero = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
    checks++;
    if ({bus.done, bus.reg_write, bus.mem_read, bus.mem_write, bus.branch_taken, bus.illegal, bus.bus_err} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 0000000",
        {bus.done, bus.reg_write, bus.mem_read, bus.mem_write, bus.branch_taken, bus.illegal, bus.bus_err});
    end
    checks++;
    if ({bus.ALUoperation, bus.op2_sel} !== 5'b0) begin errors++; $display("FAIL reset_alu: got %b want 00000", {bus.ALUoperation, bus.op2_sel}); end
    checks++;
    if ({bus.imm, bus.rs1, bus.rs2, bus.rd} !== 47'b0) begin errors++; $display("FAIL reset_fields: imm=%h rs1=%0d rs2=%0d rd=%0d want 0", bus.imm, bus.rs1, bus.rs2, bus.rd); end
    checks++;
    if (bus.retired !== 4'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_add();
    send(I_ADD);
    @(negedge clk); // DECODE
    checks++;
    if (bus.instr_ready !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL add_decode: ready=%b done=%b want 0 0", bus.instr_ready, bus.done); end
    @(negedge clk); // EXEC
    checks++;
    if (bus.ALUoperation !== 4'b0010 || bus.op2_sel !== 1'b0) begin errors++; $display("FAIL add_alu: op=%b sel=%b want 0010 0", bus.ALUoperation, bus.op2_sel); end
    checks++;
    if (bus.rd !== 5'd3 || bus.rs1 !== 5'd1 || bus.rs2 !== 5'd2) begin errors++; $display("FAIL add_fields: rd=%0d rs1=%0d rs2=%0d want 3 1 2", bus.rd, bus.rs1, bus.rs2); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL add_exec_done: got %b want 0", bus.done); end
    @(negedge clk); // WB, 3rd cycle after handshake
    checks++;
    if (bus.done !== 1'b1 || bus.reg_write !== 1'b1 || bus.branch_taken !== 1'b0) begin
      errors++; $display("FAIL add_wb: done=%b reg_write=%b branch=%b want 1 1 0", bus.done, bus.reg_write, bus.branch_taken);
    end
    @(negedge clk); // IDLE
    checks++;
    if (bus.retired !== 4'd1 || bus.done !== 1'b0 || bus.instr_ready !== 1'b1) begin
      errors++; $display("FAIL add_after: retired=%0d done=%b ready=%b want 1 0 1", bus.retired, bus.done, bus.instr_ready);
    end
  endtask

  task automatic test_beq(input logic z, input logic [CNT_W-1:0] exp_ret);
    send(I_BEQ);
    @(negedge clk); // DECODE
    bus.zero = z;
    @(negedge clk); // EXEC
    checks++;
    if (bus.ALUoperation !== 4'b0110 || bus.op2_sel !== 1'b0 || bus.imm !== 32'd8) begin
      errors++; $display("FAIL beq_exec: op=%b sel=%b imm=%0d want 0110 0 8", bus.ALUoperation, bus.op2_sel, bus.imm);
    end
    @(negedge clk); // WB
    bus.zero = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.branch_taken !== z || bus.reg_write !== 1'b0) begin
      errors++; $display("FAIL beq_wb_z%0d: done=%b branch=%b reg_write=%b want 1 %b 0", z, bus.done, bus.branch_taken, bus.reg_write, z);
    end
    @(negedge clk);
    checks++;
    if (bus.retired !== exp_ret) begin errors++; $display("FAIL beq_retired: got %0d want %0d", bus.retired, exp_ret); end
  endtask

  task automatic test_lw();
    int rd_cycles;
    rd_cycles = 0;
    send(I_LW);
    @(negedge clk); // DECODE
    @(negedge clk); // EXEC
    checks++;
    if (bus.ALUoperation !== 4'b0010 || bus.op2_sel !== 1'b1 || bus.imm !== 32'd4 || bus.rd !== 5'd3) begin
      errors++; $display("FAIL lw_exec: op=%b sel=%b imm=%0d rd=%0d want 0010 1 4 3", bus.ALUoperation, bus.op2_sel, bus.imm, bus.rd);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.mem_read === 1'b1 && bus.mem_write === 1'b0) rd_cycles++;
      if (i == 4) bus.mem_ack = 1'b1;
    end
    @(negedge clk); // WB
    bus.mem_ack = 1'b0;
    checks++;
    if (rd_cycles != 5) begin errors++; $display("FAIL lw_mem_read_cycles: got %0d want 5", rd_cycles); end
    checks++;
    if (bus.done !== 1'b1 || bus.reg_write !== 1'b1 || bus.mem_read !== 1'b0) begin
      errors++; $display("FAIL lw_wb: done=%b reg_write=%b mem_read=%b want 1 1 0", bus.done, bus.reg_write, bus.mem_read);
    end
    @(negedge clk);
    checks++;
    if (bus.retired !== 4'd4) begin errors++; $display("FAIL lw_retired: got %0d want 4", bus.retired); end
  endtask

  task automatic test_sw_timeout();
    int wr_cycles;
    int err_cycle;
    int err_count;
    logic seen_done;
    wr_cycles = 0; err_cycle = -1; err_count = 0; seen_done = 1'b0;
    send(I_SW);
    @(negedge clk); // DECODE
    @(negedge clk); // EXEC
    checks++;
    if (bus.imm !== 32'd8 || bus.op2_sel !== 1'b1 || bus.ALUoperation !== 4'b0010) begin
      errors++; $display("FAIL sw_exec: imm=%0d sel=%b op=%b want 8 1 0010", bus.imm, bus.op2_sel, bus.ALUoperation);
    end
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      @(negedge clk);
      if (bus.mem_write === 1'b1) wr_cycles++;
      if (bus.bus_err === 1'b1) begin err_count++; err_cycle = i; end
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    @(negedge clk);
    if (bus.done === 1'b1) seen_done = 1'b1;
    checks++;
    if (wr_cycles != MEM_TIMEOUT) begin errors++; $display("FAIL sw_mem_write_cycles: got %0d want %0d", wr_cycles, MEM_TIMEOUT); end
    checks++;
    if (err_count != 1 || err_cycle != MEM_TIMEOUT - 1) begin
      errors++; $display("FAIL sw_bus_err: pulses=%0d at MEM cycle %0d want 1 at %0d", err_count, err_cycle + 1, MEM_TIMEOUT);
    end
    checks++;
    if (seen_done !== 1'b0 || bus.retired !== 4'd4 || bus.instr_ready !== 1'b1 || bus.mem_write !== 1'b0) begin
      errors++; $display("FAIL sw_after: done_seen=%b retired=%0d ready=%b mem_write=%b want 0 4 1 0", seen_done, bus.retired, bus.instr_ready, bus.mem_write);
    end
  endtask

  task automatic test_illegal();
    send(32'hFFFFFFFF);
    @(negedge clk); // DECODE
    checks++;
    if (bus.illegal !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL illegal_pulse: illegal=%b done=%b want 1 0", bus.illegal, bus.done); end
    @(negedge clk);
    checks++;
    if (bus.illegal !== 1'b0 || bus.instr_ready !== 1'b1 || bus.retired !== 4'd4) begin
      errors++; $display("FAIL illegal_after: illegal=%b ready=%b retired=%0d want 0 1 4", bus.illegal, bus.instr_ready, bus.retired);
    end
  endtask

  task automatic test_reset_mid_mem();
    send(I_LW);
    repeat (3) @(negedge clk); // DECODE, EXEC, first MEM cycle
    checks++;
    if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL rstmem_in_mem: mem_read=%b want 1", bus.mem_read); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.done, bus.reg_write, bus.bus_err} !== 5'b0 || bus.retired !== 4'd0 || bus.instr_ready !== 1'b1) begin
      errors++; $display("FAIL rstmem_abort: strobes=%b retired=%0d ready=%b want 00000 0 1",
        {bus.mem_read, bus.mem_write, bus.done, bus.reg_write, bus.bus_err}, bus.retired, bus.instr_ready);
    end
    bus.mem_ack = 1'b1; // must not matter while in reset
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.retired !== 4'd0) begin errors++; $display("FAIL rstmem_after: done=%b retired=%0d want 0 0", bus.done, bus.retired); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 15; i++) run_add();
    checks++;
    if (bus.retired !== 4'd15) begin errors++; $display("FAIL wrap_preload: got %0d want 15", bus.retired); end
    run_add();
    checks++;
    if (bus.retired !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", bus.retired); end
  endtask

  // instr_valid stays high with a different word through DECODE/EXEC/WB; it must be ignored.
  task automatic test_ignore_valid();
    logic seen_done;
    seen_done = 1'b0;
    @(negedge clk);
    bus.instr = I_ADD;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr = I_ADD4;
    @(negedge clk); // DECODE
    @(negedge clk); // EXEC
    checks++;
    if (bus.rd !== 5'd3) begin errors++; $display("FAIL ignore_rd_exec: got %0d want 3", bus.rd); end
    @(negedge clk); // WB
    checks++;
    if (bus.done !== 1'b1 || bus.rd !== 5'd3) begin errors++; $display("FAIL ignore_wb: done=%b rd=%0d want 1 3", bus.done, bus.rd); end
    bus.instr_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (bus.retired !== 4'd1 || seen_done !== 1'b0 || bus.instr_ready !== 1'b1) begin
      errors++; $display("FAIL ignore_after: retired=%0d extra_done=%b ready=%b want 1 0 1", bus.retired, seen_done, bus.instr_ready);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_beq(1'b1, 4'd2);
    test_beq(1'b0, 4'd3);
    test_lw();
    test_sw_timeout();
    test_illegal();
    test_reset_mid_mem();
    test_wrap();
    test_ignore_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
